// File: rtl/ppu_fb_writer.sv
// Generates the 256x240 palette-index raster and drives the frame buffer write port from a source stream or test patterns.
// Latency 1 cycle from pixel accept to CS; the source stalls the raster via src_valid, and src_ready is high only in ACTIVE.
module ppu_fb_writer #(
    parameter int H_PIX         = 256,
    parameter int V_PIX         = 240,
    parameter int VBLANK_CYCLES = 6820
) (
    input  logic       ppu_clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cont,
    input  logic [1:0] mode,
    input  logic [5:0] solid_color,
    input  logic       src_valid,
    input  logic [5:0] src_data,
    output logic       src_ready,
    output logic [7:0] ppu_ptr_x,
    output logic [7:0] ppu_ptr_y,
    output logic [5:0] ppu_DI,
    output logic       CS,
    output logic       busy,
    output logic       vblank,
    output logic       frame_done,
    output logic [7:0] frame_cnt
);

    localparam int              VB_W    = (VBLANK_CYCLES > 1) ? $clog2(VBLANK_CYCLES) : 1;
    localparam logic [7:0]      X_LAST  = 8'(H_PIX - 1);
    localparam logic [7:0]      Y_LAST  = 8'(V_PIX - 1);
    localparam logic [VB_W-1:0] VB_LOAD = VB_W'(VBLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_VBLANK = 2'd2
    } state_t;

    state_t          state_q;
    logic [1:0]      mode_q;
    logic [5:0]      solid_q;
    logic [7:0]      x_q, y_q, x_d, y_d;
    logic [VB_W-1:0] vb_cnt_q;
    logic [7:0]      ptr_x_q, ptr_y_q, frame_cnt_q;
    logic [5:0]      di_q, pix_d;
    logic            cs_q, frame_done_q;
    logic            accept, last_pix;

    function automatic logic [5:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 6'h30;
            3'd1:    return 6'h28;
            3'd2:    return 6'h2C;
            3'd3:    return 6'h2A;
            3'd4:    return 6'h24;
            3'd5:    return 6'h16;
            3'd6:    return 6'h12;
            default: return 6'h0F;
        endcase
    endfunction

    assign src_ready = (state_q == ST_ACTIVE);
    assign accept    = src_ready && ((mode_q != 2'd0) || src_valid);
    assign last_pix  = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        pix_d = solid_q;
        case (mode_q)
            2'd0:    pix_d = src_data;
            2'd1:    pix_d = bar_color(x_q[7:5]);
            2'd2:    pix_d = (x_q[3] ^ y_q[3]) ? 6'h30 : 6'h0F;
            default: pix_d = solid_q;
        endcase
    end

    // Raster advances only on acceptance so source gaps never skip a pixel.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (accept) begin
            if (x_q == X_LAST) begin
                x_d = 8'd0;
                y_d = (y_q == Y_LAST) ? 8'd0 : y_q + 8'd1;
            end else begin
                x_d = x_q + 8'd1;
            end
        end
    end

    always_ff @(posedge ppu_clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= 2'd0;
            solid_q      <= 6'd0;
            x_q          <= 8'd0;
            y_q          <= 8'd0;
            vb_cnt_q     <= '0;
            ptr_x_q      <= 8'd0;
            ptr_y_q      <= 8'd0;
            di_q         <= 6'd0;
            cs_q         <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'd0;
        end else begin
            cs_q         <= accept;
            frame_done_q <= accept && last_pix;
            x_q          <= x_d;
            y_q          <= y_d;
            if (frame_done_q) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            if (accept) begin
                ptr_x_q <= x_q;
                ptr_y_q <= y_q;
                di_q    <= pix_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_ACTIVE;
                        mode_q  <= mode;
                        solid_q <= solid_color;
                    end
                end
                ST_ACTIVE: begin
                    // The last pixel's output cycle is already the first VBLANK cycle.
                    if (accept && last_pix) begin
                        state_q  <= ST_VBLANK;
                        vb_cnt_q <= VB_LOAD;
                    end
                end
                ST_VBLANK: begin
                    if (vb_cnt_q == '0) begin
                        if (cont) begin
                            state_q <= ST_ACTIVE;
                            mode_q  <= mode;
                            solid_q <= solid_color;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        vb_cnt_q <= vb_cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ppu_ptr_x  = ptr_x_q;
    assign ppu_ptr_y  = ptr_y_q;
    assign ppu_DI     = di_q;
    assign CS         = cs_q;
    assign busy       = (state_q != ST_IDLE);
    assign vblank     = (state_q == ST_VBLANK);
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Directed bench: full-size frame in colour-bar mode, plus reduced-raster instances for stream, solid, checker, reset and wrap.
module tb_ppu_fb_writer;

    localparam int S_H  = 16;
    localparam int S_V  = 16;
    localparam int S_VB = 10;
    localparam int S_PIX = S_H * S_V;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] bar_ref(input logic [7:0] x);
        logic [5:0] tbl [8];
        tbl = '{6'h30, 6'h28, 6'h2C, 6'h2A, 6'h24, 6'h16, 6'h12, 6'h0F};
        return tbl[x[7:5]];
    endfunction

    function automatic logic [5:0] exp_di(input logic [1:0] md, input logic [5:0] sc,
                                          input logic [7:0] x, input logic [7:0] y,
                                          input logic [5:0] dat);
        case (md)
            2'd0:    return dat;
            2'd1:    return bar_ref(x);
            2'd2:    return (x[3] ^ y[3]) ? 6'h30 : 6'h0F;
            default: return sc;
        endcase
    endfunction

    // ---------------- full-size instance ----------------
    logic b_rst = 1'b0, b_start = 1'b0, b_cont = 1'b0, b_valid = 1'b0;
    logic [1:0] b_mode = 2'd0;
    logic [5:0] b_solid = 6'd0, b_data = 6'd0, b_di;
    logic [7:0] b_px, b_py, b_fcnt;
    logic b_rdy, b_cs, b_busy, b_vb, b_fd;

    ppu_fb_writer u_big (
        .ppu_clk(clk), .rst(b_rst), .start(b_start), .cont(b_cont), .mode(b_mode),
        .solid_color(b_solid), .src_valid(b_valid), .src_data(b_data), .src_ready(b_rdy),
        .ppu_ptr_x(b_px), .ppu_ptr_y(b_py), .ppu_DI(b_di), .CS(b_cs), .busy(b_busy),
        .vblank(b_vb), .frame_done(b_fd), .frame_cnt(b_fcnt)
    );

    // ---------------- reduced raster instance ----------------
    logic s_rst = 1'b0, s_start = 1'b0, s_cont = 1'b0, s_valid = 1'b0;
    logic [1:0] s_mode = 2'd0;
    logic [5:0] s_solid = 6'd0, s_data = 6'd0, s_di;
    logic [7:0] s_px, s_py, s_fcnt;
    logic s_rdy, s_cs, s_busy, s_vb, s_fd;
    logic [5:0] s_seq = 6'd0;

    ppu_fb_writer #(.H_PIX(S_H), .V_PIX(S_V), .VBLANK_CYCLES(S_VB)) u_sm (
        .ppu_clk(clk), .rst(s_rst), .start(s_start), .cont(s_cont), .mode(s_mode),
        .solid_color(s_solid), .src_valid(s_valid), .src_data(s_data), .src_ready(s_rdy),
        .ppu_ptr_x(s_px), .ppu_ptr_y(s_py), .ppu_DI(s_di), .CS(s_cs), .busy(s_busy),
        .vblank(s_vb), .frame_done(s_fd), .frame_cnt(s_fcnt)
    );

    // ---------------- wrap instance ----------------
    logic w_rst = 1'b0, w_start = 1'b0, w_cont = 1'b0, w_valid = 1'b0;
    logic [1:0] w_mode = 2'd0;
    logic [5:0] w_solid = 6'd0, w_data = 6'd0, w_di;
    logic [7:0] w_px, w_py, w_fcnt;
    logic w_rdy, w_cs, w_busy, w_vb, w_fd;

    ppu_fb_writer #(.H_PIX(4), .V_PIX(2), .VBLANK_CYCLES(4)) u_wrap (
        .ppu_clk(clk), .rst(w_rst), .start(w_start), .cont(w_cont), .mode(w_mode),
        .solid_color(w_solid), .src_valid(w_valid), .src_data(w_data), .src_ready(w_rdy),
        .ppu_ptr_x(w_px), .ppu_ptr_y(w_py), .ppu_DI(w_di), .CS(w_cs), .busy(w_busy),
        .vblank(w_vb), .frame_done(w_fd), .frame_cnt(w_fcnt)
    );

    // Entered at the negedge of the first ACTIVE cycle; returns at the negedge showing the last pixel.
    task automatic s_frame(input logic [1:0] md, input logic [5:0] sc, input bit rnd, input bit mid_start);
        int got = 0;
        int cyc = 0;
        int cs_seen = 0;
        bit pend, last;
        logic [5:0] pdat, edi;
        logic [7:0] ex = 8'd0, ey = 8'd0;
        chk("s_first_nocs", 64'(s_cs), 64'(0));
        chk("s_first_rdy", 64'(s_rdy), 64'(1));
        while (got < S_PIX && cyc < 4 * S_PIX) begin
            s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = s_seq;
            s_start = mid_start && (got == 37);
            pend    = s_rdy && ((md != 2'd0) || s_valid);
            pdat    = s_seq;
            if (pend && md == 2'd0) s_seq = s_seq + 6'd1;
            @(negedge clk);
            cyc++;
            s_start = 1'b0;
            if (s_cs) cs_seen++;
            if (pend) begin
                edi  = exp_di(md, sc, ex, ey, pdat);
                last = (ex == 8'(S_H - 1)) && (ey == 8'(S_V - 1));
                chk("s_pix", 64'({s_cs, s_fd, s_vb, s_px, s_py, s_di}),
                    64'({1'b1, last, last, ex, ey, edi}));
                if (md == 2'd2 && ex == 8'd8 && ey == 8'd0) chk("s_chk_8_0", 64'(s_di), 64'(6'h30));
                if (md == 2'd2 && ex == 8'd8 && ey == 8'd8) chk("s_chk_8_8", 64'(s_di), 64'(6'h0F));
                if (ex == 8'(S_H - 1)) begin
                    ex = 8'd0;
                    ey = ey + 8'd1;
                end else begin
                    ex = ex + 8'd1;
                end
                got++;
            end else begin
                chk("s_gap_nocs", 64'(s_cs), 64'(0));
            end
        end
        chk("s_frame_pixels", 64'(got), 64'(S_PIX));
        chk("s_cs_count", 64'(cs_seen), 64'(got));
    endtask

    task automatic s_vblank(output int n);
        n = 1;
        s_valid = 1'b1;
        @(negedge clk);
        while (s_vb && n < 100) begin
            chk("s_vb_idle_port", 64'({s_cs, s_rdy}), 64'(0));
            n++;
            @(negedge clk);
        end
    endtask

    task automatic big_run;
        int n;
        bit last;
        logic [7:0] ex, ey;
        repeat (2) @(negedge clk);
        chk("b_reset", 64'({b_px, b_py, b_di, b_cs, b_rdy, b_busy, b_vb, b_fd, b_fcnt}), 64'(0));
        b_rst   = 1'b1;
        b_mode  = 2'd1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        b_mode  = 2'd3;
        chk("b_first", 64'({b_rdy, b_cs, b_busy}), 64'(3'b101));
        for (int i = 0; i < 256 * 240; i++) begin
            @(negedge clk);
            ex   = 8'(i % 256);
            ey   = 8'(i / 256);
            last = (i == 256 * 240 - 1);
            chk("b_pix", 64'({b_cs, b_fd, b_vb, b_px, b_py, b_di, b_fcnt}),
                64'({1'b1, last, last, ex, ey, bar_ref(ex), 8'd0}));
            if (i == 31)          chk("b_bar_31_0", 64'(b_di), 64'(6'h30));
            if (i == 32)          chk("b_bar_32_0", 64'(b_di), 64'(6'h28));
            if (i == 100*256+255) chk("b_bar_255_100", 64'(b_di), 64'(6'h0F));
        end
        n = 1;
        @(negedge clk);
        chk("b_fcnt_after", 64'(b_fcnt), 64'(1));
        while (b_vb && n < 8000) begin
            if (b_cs) chk("b_vb_nocs", 64'(b_cs), 64'(0));
            n++;
            @(negedge clk);
        end
        chk("b_vb_len", 64'(n), 64'(6820));
        chk("b_idle", 64'({b_busy, b_cs, b_fcnt}), 64'({1'b0, 1'b0, 8'd1}));
    endtask

    task automatic small_run;
        int n, k;
        repeat (2) @(negedge clk);
        chk("s_reset", 64'({s_px, s_py, s_di, s_cs, s_rdy, s_busy, s_vb, s_fd, s_fcnt}), 64'(0));
        s_rst = 1'b1;
        // solid colour, inputs changed after start to prove latching
        s_mode = 2'd3; s_solid = 6'h21; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0; s_mode = 2'd0; s_solid = 6'h00;
        s_frame(2'd3, 6'h21, 1'b0, 1'b0);
        s_vblank(n);
        chk("s_vb_len_solid", 64'(n), 64'(S_VB));
        chk("s_idle_solid", 64'({s_busy, s_fcnt}), 64'({1'b0, 8'd1}));
        // source stream with random gaps; data offered in IDLE is not consumed
        s_valid = 1'b1;
        @(negedge clk);
        chk("s_idle_rdy", 64'({s_rdy, s_cs}), 64'(0));
        s_mode = 2'd0; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        s_frame(2'd0, 6'h00, 1'b1, 1'b0);
        s_vblank(n);
        chk("s_vb_len_stream", 64'(n), 64'(S_VB));
        chk("s_idle_stream", 64'({s_busy, s_fcnt}), 64'({1'b0, 8'd2}));
        // reset asserted while pixel (10,5) is on the port
        s_mode = 2'd2; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        k = 0;
        while (!(s_cs && s_px == 8'd10 && s_py == 8'd5) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("s_reach_10_5", 64'(k < 400), 64'(1));
        s_rst = 1'b0;
        @(negedge clk);
        chk("s_midreset", 64'({s_px, s_py, s_di, s_cs, s_rdy, s_busy, s_vb, s_fd, s_fcnt}), 64'(0));
        s_rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("s_post_reset_idle", 64'({s_cs, s_busy}), 64'(0));
        end
        // back-to-back checkerboard frames, stray start pulses mid-frame
        s_mode = 2'd2; s_cont = 1'b1; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int f = 0; f < 3; f++) begin
            if (f == 2) s_cont = 1'b0;
            s_frame(2'd2, 6'h00, 1'b0, 1'b1);
            s_vblank(n);
            chk("s_vb_len_cont", 64'(n), 64'(S_VB));
        end
        chk("s_cont_done", 64'({s_busy, s_fcnt}), 64'({1'b0, 8'd3}));
    endtask

    task automatic wrap_run;
        int pulses = 0;
        int k = 0;
        repeat (2) @(negedge clk);
        w_rst = 1'b1; w_cont = 1'b1; w_mode = 2'd1; w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        while (pulses < 256 && k < 5000) begin
            @(negedge clk);
            k++;
            if (w_fd) begin
                pulses++;
                if (pulses == 256) begin
                    chk("w_cnt_before_wrap", 64'(w_fcnt), 64'(255));
                    w_cont = 1'b0;
                end
            end
        end
        k = 0;
        while (w_busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("w_pulses", 64'(pulses), 64'(256));
        chk("w_wrapped", 64'({w_busy, w_fcnt}), 64'(0));
        repeat (3) @(negedge clk);
        chk("w_quiet", 64'({w_cs, w_fd, w_fcnt}), 64'(0));
    endtask

    initial begin
        fork
            big_run();
            small_run();
            wrap_run();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
